discharge_ctrl: RTL and testbench
=================================

Name: discharge_ctrl

Overview:
Sequences EDM discharge pulses from the SPI command/parameter strobes. It holds shadow copies of Ton, Toff, Ip and waveform and commits them at pulse boundaries. It drives the MOSFET gates PWM[7:0] and the series cut-off pair PWM_Q[1:0] through an IDLE/DEAD_ON/TON/DEAD_OFF/TOFF state machine with dead-time insertion, and it reports pulse statistics.

Parameters:
TICK_DIV, 10, clocks per time tick (100 ns at 100 MHz); Ton/Toff/step counts are in ticks
DEAD_CYC, 4, dead-time clocks between PWM_Q and PWM edges
MIN_TOFF, 2, minimum Toff in ticks (clamp)

Ports:
sys_clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
machine_start_ack  in  1  one-cycle start strobe
machine_stop_ack  in  1  one-cycle stop strobe
Ton_data  in  16  on-time, ticks
change_Ton_ack  in  1  load strobe for Ton_data
Toff_data  in  16  off-time, ticks
change_Toff_ack  in  1  load strobe for Toff_data
Ip_data  in  16  [3:0] = number of parallel channels
change_Ip_ack  in  1  load strobe for Ip_data
waveform_data  in  16  [0] = staircase enable, [15:8] = step length in ticks
change_waveform_ack  in  1  load strobe for waveform_data
short_flag  in  1  gap short detected, synchronous to sys_clk
PWM  out  8  main MOSFET gates
PWM_Q  out  2  cut-off switch gates
running  out  1  machine started
pulse_cnt  out  16  completed pulses, wrapping
short_cnt  out  16  short-aborted pulses, wrapping

Behaviour:
- Reset: all outputs 0, state IDLE. Shadow registers reset to Ton=10, Toff=50, Ip=1, waveform=0.
- Any change_*_ack loads its shadow on the next edge, in any state.
- Active registers copy from the shadows on IDLE->DEAD_ON and on TOFF->DEAD_ON only. A change never alters the pulse in progress.
- Clamps at commit: Ton=0 becomes 1. Toff<MIN_TOFF becomes MIN_TOFF. Ip[3:0]>8 becomes 8. Step length 0 becomes 1.
- Channel mask = (1<<n)-1, where n is the clamped Ip. Ip=0 gives an open-gap pulse: timing runs, PWM stays 0.
- Timing: a prescaler restarts on every state entry, so a state lasting X ticks lasts exactly X*TICK_DIV clocks.
- IDLE: PWM=0, PWM_Q=0. A start strobe with no stop strobe in the same cycle sets running=1 and moves to DEAD_ON on the next edge.
- DEAD_ON (DEAD_CYC clocks): PWM_Q=2'b11, PWM=0.
- TON (Ton ticks), rectangular (waveform[0]=0): PWM=mask for the whole state.
- TON, staircase (waveform[0]=1): PWM starts at 8'h01 and adds one channel every step ticks until it reaches mask.
- DEAD_OFF (DEAD_CYC clocks): PWM=0, PWM_Q=2'b11. On exit pulse_cnt increments.
- TOFF (Toff ticks, doubled after a short abort): all gates 0, then DEAD_ON.
- Stop strobe in DEAD_ON or TON: go to DEAD_OFF, then IDLE; running=0.
- Stop strobe in TOFF: go to IDLE.
- Stop wins over a simultaneous start. Start while running is ignored.
- PWM and PWM_Q are registered. PWM changes on the edge after the state decision. PWM never overlaps PWM_Q=0.
- Reset mid-operation forces all gates 0 immediately (asynchronous).

Optional Feature:
SHORT_PROTECT_EN
- Defined: short_flag high in TON aborts to DEAD_OFF on the next edge. short_cnt increments, and the following TOFF lasts 2*Toff ticks (saturating at 16'hFFFF).
- Undefined: short_flag is ignored and short_cnt is tied to 0.

Decomposition:
- Shared package edm_pkg: state encoding, TIME_W=16, MAX_CH=8, reset defaults for the shadow registers.
- One sub-module, tick_timer: prescaler plus tick down-counter with load/restart, timeout pulse and step pulse outputs. It is instantiated once and reused by all states.

Test Plan:
1. Ton=5, Toff=10, Ip=3, rectangular, start -> PWM=8'h07 for 50 clocks; PWM_Q=2'b11 for 58 clocks; 100 clocks off; pulse_cnt=1 after the first DEAD_OFF.
2. Ton changed to 8 mid-TON -> current PWM window stays 50 clocks; next window is 80 clocks.
3. Stop strobe during TON -> PWM=0 on the next edge; PWM_Q=0 4 clocks later; running=0; state IDLE; simultaneous start+stop from IDLE -> stays IDLE.
4. SHORT_PROTECT_EN, short_flag during TON -> PWM=0 on the next edge; short_cnt=1; following TOFF is 200 clocks. Without the macro -> full 50-clock pulse, short_cnt=0.
5. Ton=0, Toff=0, Ip=12 -> 10-clock PWM=8'hFF window and 20-clock TOFF.
6. waveform_data=16'h0201, Ip=4, Ton=10 -> PWM steps 01, 03, 07, 0F at 20-clock spacing, holds 0F to the end of TON; rst_n low mid-TON -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/edm_pkg.sv
// -----------------------------------------------------------------------------
// edm_pkg
// Shared definitions for the EDM discharge controller:
//   - state_e      : discharge sequencer state encoding
//   - TIME_W       : width of all tick/time quantities
//   - MAX_CH       : number of parallel MOSFET channels
//   - *_RST        : reset defaults of the parameter shadow registers
//   - ch_mask()    : channel-count to gate-mask conversion
// Optional feature macro used by the controller: SHORT_PROTECT_EN
// -----------------------------------------------------------------------------
package edm_pkg;

  localparam int TIME_W = 16;
  localparam int MAX_CH = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEAD_ON  = 3'd1,
    ST_TON      = 3'd2,
    ST_DEAD_OFF = 3'd3,
    ST_TOFF     = 3'd4
  } state_e;

  localparam logic [TIME_W-1:0] TON_RST  = 16'd10;
  localparam logic [TIME_W-1:0] TOFF_RST = 16'd50;
  localparam logic [TIME_W-1:0] IP_RST   = 16'd1;
  localparam logic [TIME_W-1:0] WAVE_RST = 16'd0;

  // n channels -> (1<<n)-1; n is expected to be clamped to MAX_CH already.
  function automatic logic [MAX_CH-1:0] ch_mask(input logic [3:0] n);
    logic [MAX_CH-1:0] m;
    if (n >= 4'(MAX_CH)) m = '1;
    else                 m = (MAX_CH'(1) << n) - MAX_CH'(1);
    return m;
  endfunction

endpackage

// File: rtl/discharge_ctrl_tick_timer.sv
// -----------------------------------------------------------------------------
// tick_timer
// Single interval timer shared by every sequencer state.
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : restart the interval (prescaler, counter and step counter)
//   raw          : 1 = count raw clocks, 0 = count ticks of TICK_DIV clocks
//   load_val     : interval length (clocks or ticks, see raw)
//   step_len     : staircase step length in ticks
//   timeout      : high during the last clock of the interval
//   step         : high during the last clock of every step_len-tick period
// -----------------------------------------------------------------------------
module tick_timer #(
  parameter int TICK_DIV = 10,
  parameter int TIME_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              raw,
  input  logic [TIME_W-1:0] load_val,
  input  logic [7:0]        step_len,
  output logic              timeout,
  output logic              step
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]  pre_q,      pre_d;
  logic [TIME_W-1:0] cnt_q,      cnt_d;
  logic [7:0]        step_cnt_q, step_cnt_d;
  logic              raw_q,      raw_d;
  logic              tick;

  assign tick    = raw_q || (pre_q == PRE_W'(TICK_DIV - 1));
  assign timeout = tick && (cnt_q == TIME_W'(1));
  assign step    = tick && (step_cnt_q == 8'd1);

  always_comb begin
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    step_cnt_d = step_cnt_q;
    raw_d      = raw_q;
    if (load) begin
      // Restarting the prescaler on entry makes an X-tick state exactly
      // X*TICK_DIV clocks long regardless of where the previous one ended.
      pre_d      = '0;
      cnt_d      = load_val;
      step_cnt_d = step_len;
      raw_d      = raw;
    end else begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
      if (tick && (cnt_q != '0)) cnt_d = cnt_q - TIME_W'(1);
      if (tick) step_cnt_d = (step_cnt_q <= 8'd1) ? step_len : step_cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q      <= '0;
      cnt_q      <= '0;
      step_cnt_q <= '0;
      raw_q      <= 1'b1;
    end else begin
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      step_cnt_q <= step_cnt_d;
      raw_q      <= raw_d;
    end
  end

endmodule

// File: rtl/discharge_ctrl.sv
// -----------------------------------------------------------------------------
// discharge_ctrl
// EDM discharge pulse sequencer. Parameter writes land in shadow registers and
// are committed to the active set only at pulse boundaries (IDLE->DEAD_ON and
// TOFF->DEAD_ON), so a pulse in progress is never altered.
// Sequence: IDLE -> DEAD_ON -> TON -> DEAD_OFF -> TOFF -> DEAD_ON ...
// Ports:
//   sys_clk, rst_n            : clock, asynchronous active-low reset
//   machine_start/stop_ack    : one-cycle start / stop strobes
//   Ton/Toff/Ip/waveform_data : parameter values, loaded by change_*_ack
//   short_flag                : gap short detected
//   PWM[7:0]                  : main MOSFET gates (registered)
//   PWM_Q[1:0]                : series cut-off gates (registered)
//   running                   : machine started
//   pulse_cnt, short_cnt      : wrapping pulse / short-abort counters
// Optional feature macro: SHORT_PROTECT_EN (short abort in TON, doubled TOFF)
// -----------------------------------------------------------------------------
module discharge_ctrl
  import edm_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int DEAD_CYC = 4,
  parameter int MIN_TOFF = 2
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        machine_start_ack,
  input  logic        machine_stop_ack,
  input  logic [15:0] Ton_data,
  input  logic        change_Ton_ack,
  input  logic [15:0] Toff_data,
  input  logic        change_Toff_ack,
  input  logic [15:0] Ip_data,
  input  logic        change_Ip_ack,
  input  logic [15:0] waveform_data,
  input  logic        change_waveform_ack,
  input  logic        short_flag,
  output logic [7:0]  PWM,
  output logic [1:0]  PWM_Q,
  output logic        running,
  output logic [15:0] pulse_cnt,
  output logic [15:0] short_cnt
);

  // Clamps applied when the shadow set is committed.
  function automatic logic [TIME_W-1:0] clamp_ton(input logic [TIME_W-1:0] v);
    return (v == '0) ? TIME_W'(1) : v;
  endfunction

  function automatic logic [TIME_W-1:0] clamp_toff(input logic [TIME_W-1:0] v);
    return (v < TIME_W'(MIN_TOFF)) ? TIME_W'(MIN_TOFF) : v;
  endfunction

  function automatic logic [3:0] clamp_ip(input logic [3:0] v);
    return (v > 4'(MAX_CH)) ? 4'(MAX_CH) : v;
  endfunction

  function automatic logic [7:0] clamp_step(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  function automatic logic [TIME_W-1:0] sat_double(input logic [TIME_W-1:0] v);
    return v[TIME_W-1] ? '1 : {v[TIME_W-2:0], 1'b0};
  endfunction

  state_e state_q, state_d;

  // Shadow parameter set
  logic [TIME_W-1:0] ton_sh_q,   ton_sh_d;
  logic [TIME_W-1:0] toff_sh_q,  toff_sh_d;
  logic [3:0]        ip_sh_q,    ip_sh_d;
  logic              stair_sh_q, stair_sh_d;
  logic [7:0]        step_sh_q,  step_sh_d;

  // Active (committed, clamped) parameter set
  logic [TIME_W-1:0] ton_q,      ton_d;
  logic [TIME_W-1:0] toff_q,     toff_d;
  logic [MAX_CH-1:0] mask_q,     mask_d;
  logic              stair_en_q, stair_en_d;
  logic [7:0]        step_len_q, step_len_d;

  logic              running_q,    running_d;
  logic [MAX_CH-1:0] pwm_q,        pwm_d;
  logic [1:0]        cut_q,        cut_d;
  logic [MAX_CH-1:0] stair_q,      stair_d;
  logic [TIME_W-1:0] pulse_cnt_q,  pulse_cnt_d;
  logic [TIME_W-1:0] short_cnt_q,  short_cnt_d;
  logic              short_pend_q, short_pend_d;

  logic              pulse_inc;
  logic              short_abort;
  logic              short_hit;
  logic              commit;
  logic              tmr_load, tmr_raw, tmr_timeout, tmr_step;
  logic [TIME_W-1:0] tmr_val;

  logic [14:0]       unused_bits;
  assign unused_bits = {Ip_data[15:4], waveform_data[7:5], waveform_data[4:1] == 4'd0};

`ifdef SHORT_PROTECT_EN
  assign short_hit = short_flag;
`else
  logic unused_short;
  assign unused_short = short_flag;
  assign short_hit    = 1'b0;
`endif

  // Sequencer next state
  always_comb begin
    state_d     = state_q;
    running_d   = running_q;
    pulse_inc   = 1'b0;
    short_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (machine_start_ack && !machine_stop_ack) begin
          state_d   = ST_DEAD_ON;
          running_d = 1'b1;
        end
      end
      ST_DEAD_ON: begin
        if (machine_stop_ack) begin
          state_d   = ST_DEAD_OFF;
          running_d = 1'b0;
        end else if (tmr_timeout) begin
          state_d = ST_TON;
        end
      end
      ST_TON: begin
        if (machine_stop_ack) begin
          state_d   = ST_DEAD_OFF;
          running_d = 1'b0;
        end else if (short_hit) begin
          state_d     = ST_DEAD_OFF;
          short_abort = 1'b1;
        end else if (tmr_timeout) begin
          state_d = ST_DEAD_OFF;
        end
      end
      ST_DEAD_OFF: begin
        // A stop seen here still lets the dead time finish, then parks.
        if (machine_stop_ack) running_d = 1'b0;
        if (tmr_timeout) begin
          pulse_inc = 1'b1;
          state_d   = (running_q && !machine_stop_ack) ? ST_TOFF : ST_IDLE;
        end
      end
      ST_TOFF: begin
        if (machine_stop_ack) begin
          state_d   = ST_IDLE;
          running_d = 1'b0;
        end else if (tmr_timeout) begin
          state_d = ST_DEAD_ON;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        running_d = 1'b0;
      end
    endcase
  end

  // Timer restart on every state change, with the length of the state entered
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_raw  = 1'b1;
    tmr_val  = TIME_W'(DEAD_CYC);
    case (state_d)
      ST_TON: begin
        tmr_raw = 1'b0;
        tmr_val = ton_q;
      end
      ST_TOFF: begin
        tmr_raw = 1'b0;
        tmr_val = short_pend_q ? sat_double(toff_q) : toff_q;
      end
      default: begin
        tmr_raw = 1'b1;
        tmr_val = TIME_W'(DEAD_CYC);
      end
    endcase
  end

  // Parameter shadows, commit, counters and gate drive
  always_comb begin
    ton_sh_d   = change_Ton_ack      ? Ton_data           : ton_sh_q;
    toff_sh_d  = change_Toff_ack     ? Toff_data          : toff_sh_q;
    ip_sh_d    = change_Ip_ack       ? Ip_data[3:0]       : ip_sh_q;
    stair_sh_d = change_waveform_ack ? waveform_data[0]   : stair_sh_q;
    step_sh_d  = change_waveform_ack ? waveform_data[15:8] : step_sh_q;

    commit     = (state_d == ST_DEAD_ON) &&
                 ((state_q == ST_IDLE) || (state_q == ST_TOFF));
    ton_d      = ton_q;
    toff_d     = toff_q;
    mask_d     = mask_q;
    stair_en_d = stair_en_q;
    step_len_d = step_len_q;
    if (commit) begin
      ton_d      = clamp_ton(ton_sh_q);
      toff_d     = clamp_toff(toff_sh_q);
      mask_d     = ch_mask(clamp_ip(ip_sh_q));
      stair_en_d = stair_sh_q;
      step_len_d = clamp_step(step_sh_q);
    end

    pulse_cnt_d = pulse_cnt_q + TIME_W'(pulse_inc);
    short_cnt_d = short_cnt_q + TIME_W'(short_abort);

    short_pend_d = short_pend_q;
    if (short_abort)     short_pend_d = 1'b1;
    else if (commit)     short_pend_d = 1'b0;

    stair_d = stair_q;
    if ((state_d == ST_TON) && (state_q != ST_TON))
      stair_d = MAX_CH'(1);
    else if ((state_q == ST_TON) && tmr_step)
      stair_d = {stair_q[MAX_CH-2:0], 1'b1};

    // Gates are decoded from the next state so they move on the same edge as
    // the state; PWM is only nonzero in TON, where PWM_Q is always 11.
    pwm_d = '0;
    if (state_d == ST_TON) pwm_d = stair_en_q ? (stair_d & mask_q) : mask_q;
    cut_d = ((state_d == ST_DEAD_ON) || (state_d == ST_TON) ||
             (state_d == ST_DEAD_OFF)) ? 2'b11 : 2'b00;
  end

  tick_timer #(
    .TICK_DIV (TICK_DIV),
    .TIME_W   (TIME_W)
  ) u_timer (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .raw      (tmr_raw),
    .load_val (tmr_val),
    .step_len (step_len_q),
    .timeout  (tmr_timeout),
    .step     (tmr_step)
  );

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ton_sh_q     <= TON_RST;
      toff_sh_q    <= TOFF_RST;
      ip_sh_q      <= IP_RST[3:0];
      stair_sh_q   <= WAVE_RST[0];
      step_sh_q    <= WAVE_RST[15:8];
      ton_q        <= TON_RST;
      toff_q       <= TOFF_RST;
      mask_q       <= ch_mask(IP_RST[3:0]);
      stair_en_q   <= 1'b0;
      step_len_q   <= 8'd1;
      running_q    <= 1'b0;
      pwm_q        <= '0;
      cut_q        <= 2'b00;
      stair_q      <= '0;
      pulse_cnt_q  <= '0;
      short_cnt_q  <= '0;
      short_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ton_sh_q     <= ton_sh_d;
      toff_sh_q    <= toff_sh_d;
      ip_sh_q      <= ip_sh_d;
      stair_sh_q   <= stair_sh_d;
      step_sh_q    <= step_sh_d;
      ton_q        <= ton_d;
      toff_q       <= toff_d;
      mask_q       <= mask_d;
      stair_en_q   <= stair_en_d;
      step_len_q   <= step_len_d;
      running_q    <= running_d;
      pwm_q        <= pwm_d;
      cut_q        <= cut_d;
      stair_q      <= stair_d;
      pulse_cnt_q  <= pulse_cnt_d;
      short_cnt_q  <= short_cnt_d;
      short_pend_q <= short_pend_d;
    end
  end

  assign PWM       = pwm_q;
  assign PWM_Q     = cut_q;
  assign running   = running_q;
  assign pulse_cnt = pulse_cnt_q;
  assign short_cnt = short_cnt_q;

endmodule

// File: tb/tb_discharge_ctrl.sv
// -----------------------------------------------------------------------------
// tb_discharge_ctrl
// Self-checking bench for discharge_ctrl. A clock-level phase model computes
// the expected outputs every cycle; directed scenarios add literal checks on
// window lengths and gate values.
// -----------------------------------------------------------------------------
module tb_discharge_ctrl;

`ifdef SHORT_PROTECT_EN
  localparam bit SHORT_EN = 1'b1;
`else
  localparam bit SHORT_EN = 1'b0;
`endif
  localparam int TDIV = 10;
  localparam int DEAD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, short_f = 1'b0;
  logic [15:0] ton_v = '0, toff_v = '0, ip_v = '0, wf_v = '0;
  logic        c_ton = 1'b0, c_toff = 1'b0, c_ip = 1'b0, c_wf = 1'b0;
  logic [7:0]  PWM;
  logic [1:0]  PWM_Q;
  logic        running;
  logic [15:0] pulse_cnt, short_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  discharge_ctrl dut (
    .sys_clk             (clk),
    .rst_n               (rst_n),
    .machine_start_ack   (start),
    .machine_stop_ack    (stop),
    .Ton_data            (ton_v),
    .change_Ton_ack      (c_ton),
    .Toff_data           (toff_v),
    .change_Toff_ack     (c_toff),
    .Ip_data             (ip_v),
    .change_Ip_ack       (c_ip),
    .waveform_data       (wf_v),
    .change_waveform_ack (c_wf),
    .short_flag          (short_f),
    .PWM                 (PWM),
    .PWM_Q               (PWM_Q),
    .running             (running),
    .pulse_cnt           (pulse_cnt),
    .short_cnt           (short_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model (phases counted in clocks) -------------
  // phase: 0 idle, 1 dead-on, 2 on, 3 dead-off, 4 off
  int m_ph, m_dur, m_left, m_run, m_pulse, m_short, m_pend;
  int s_ton, s_toff, s_ip, s_wf;
  int a_ton, a_toff, a_n, a_stair, a_step;

  // measurements of the DUT waveform, compared with literals by the scenarios
  int pwm_run, pwm_last, q_run, q_last, off_run, off_last;
  logic [7:0] pwm_peak;

  task automatic model_reset();
    m_ph = 0; m_dur = 0; m_left = 0; m_run = 0; m_pulse = 0; m_short = 0; m_pend = 0;
    s_ton = 10; s_toff = 50; s_ip = 1; s_wf = 0;
    a_ton = 10; a_toff = 50; a_n = 1; a_stair = 0; a_step = 1;
    pwm_run = 0; q_run = 0; off_run = 0;
  endtask

  task automatic enter(input int ph, input int dur);
    m_ph = ph; m_dur = dur; m_left = dur;
  endtask

  task automatic commit();
    a_ton   = (s_ton == 0) ? 1 : s_ton;
    a_toff  = (s_toff < 2) ? 2 : s_toff;
    a_n     = ((s_ip & 15) > 8) ? 8 : (s_ip & 15);
    a_stair = s_wf & 1;
    a_step  = ((s_wf >> 8) & 255) == 0 ? 1 : ((s_wf >> 8) & 255);
    m_pend  = 0;
  endtask

  function automatic int exp_pwm();
    int mask, el, lvl;
    if (m_ph != 2) return 0;
    mask = (1 << a_n) - 1;
    if (a_stair == 0) return mask;
    el  = m_dur - m_left;
    lvl = 1 + el / (a_step * TDIV);
    if (lvl > 8) lvl = 8;
    return mask & ((1 << lvl) - 1);
  endfunction

  task automatic model_step();
    int toff_t;
    case (m_ph)
      0: if (start && !stop) begin m_run = 1; commit(); enter(1, DEAD); end
      1: begin
        if (stop) begin m_run = 0; enter(3, DEAD); end
        else if (m_left == 1) enter(2, a_ton * TDIV);
        else m_left--;
      end
      2: begin
        if (stop) begin m_run = 0; enter(3, DEAD); end
        else if (SHORT_EN && short_f) begin m_short++; m_pend = 1; enter(3, DEAD); end
        else if (m_left == 1) enter(3, DEAD);
        else m_left--;
      end
      3: begin
        if (stop) m_run = 0;
        if (m_left == 1) begin
          m_pulse++;
          toff_t = m_pend ? ((2 * a_toff > 65535) ? 65535 : 2 * a_toff) : a_toff;
          if (m_run != 0) enter(4, toff_t * TDIV);
          else enter(0, 0);
        end else m_left--;
      end
      default: begin
        if (stop) begin m_run = 0; enter(0, 0); end
        else if (m_left == 1) begin commit(); enter(1, DEAD); end
        else m_left--;
      end
    endcase
    if (c_ton)  s_ton  = ton_v;
    if (c_toff) s_toff = toff_v;
    if (c_ip)   s_ip   = ip_v;
    if (c_wf)   s_wf   = wf_v;
  endtask

  // Compare at every falling edge, then advance the model with the inputs that
  // the next rising edge will sample.
  always @(negedge clk) begin
    logic [42:0] e, a;
    if (!rst_n) model_reset();
    e = {8'(exp_pwm()), ((m_ph >= 1 && m_ph <= 3) ? 2'b11 : 2'b00), 1'(m_run),
         16'(m_pulse), 16'(m_short)};
    a = {PWM, PWM_Q, running, pulse_cnt, short_cnt};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL cycle_model t=%0t actual pwm=%h q=%b run=%b pc=%0d sc=%0d required pwm=%h q=%b run=%b pc=%0d sc=%0d",
               $time, a[42:35], a[34:33], a[32], a[31:16], a[15:0],
               e[42:35], e[34:33], e[32], e[31:16], e[15:0]);
    end
    if (PWM != 0) begin pwm_run++; pwm_peak = PWM; end
    else if (pwm_run != 0) begin pwm_last = pwm_run; pwm_run = 0; end
    if (PWM_Q != 0) q_run++;
    else if (q_run != 0) begin q_last = q_run; q_run = 0; end
    if (PWM_Q == 0 && running) off_run++;
    else if (off_run != 0) begin off_last = off_run; off_run = 0; end
    if (rst_n) model_step();
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic nclk();
    @(negedge clk); #1;
  endtask

  task automatic strobe(input bit s_start, input bit s_stop, input bit s_short);
    @(posedge clk); #1;
    start = s_start; stop = s_stop; short_f = s_short;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0; short_f = 1'b0;
  endtask

  task automatic load(input int which, input logic [15:0] v);
    @(posedge clk); #1;
    case (which)
      0: begin ton_v = v;  c_ton = 1'b1; end
      1: begin toff_v = v; c_toff = 1'b1; end
      2: begin ip_v = v;   c_ip = 1'b1; end
      default: begin wf_v = v; c_wf = 1'b1; end
    endcase
    @(posedge clk); #1;
    c_ton = 1'b0; c_toff = 1'b0; c_ip = 1'b0; c_wf = 1'b0;
  endtask

  task automatic wait_pwm_on(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nclk();
      if (PWM != 0) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  task automatic wait_pulse(input string nm, input int tgt);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      nclk();
      if (pulse_cnt == 16'(tgt)) begin ok = 1'b1; break; end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  // ---------------- directed scenarios ---------------------------------------
  initial begin
    int tgt;
    pwm_last = 0; q_last = 0; off_last = 0; pwm_peak = '0;
    repeat (4) nclk();
    chk("rst_pwm", 32'(PWM), 32'h0);
    chk("rst_pwm_q", 32'(PWM_Q), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_pulse_cnt", 32'(pulse_cnt), 32'h0);
    chk("rst_short_cnt", 32'(short_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) nclk();

    // 1: Ton=5 Toff=10 Ip=3 rectangular
    load(0, 16'd5); load(1, 16'd10); load(2, 16'd3); load(3, 16'h0000);
    strobe(1'b1, 1'b0, 1'b0);
    wait_pulse("t1_wait_pulse1", 1);
    chk("t1_pulse_cnt", 32'(pulse_cnt), 32'd1);
    chk("t1_pwm_window", 32'(pwm_last), 32'd50);
    chk("t1_pwm_value", 32'(pwm_peak), 32'h07);
    chk("t1_pwm_q_window", 32'(q_last), 32'd58);

    // 2: Ton change mid-TON affects only the following pulse
    wait_pwm_on("t2_wait_on");
    chk("t1_toff_window", 32'(off_last), 32'd100);
    load(0, 16'd8);
    wait_pulse("t2_wait_pulse2", 2);
    chk("t2_cur_window", 32'(pwm_last), 32'd50);
    wait_pulse("t2_wait_pulse3", 3);
    chk("t2_next_window", 32'(pwm_last), 32'd80);

    // 3: stop during TON, then start+stop from IDLE
    wait_pwm_on("t3_wait_on");
    repeat (5) nclk();
    strobe(1'b0, 1'b1, 1'b0);
    nclk();
    chk("t3_pwm_off_next_edge", 32'(PWM), 32'h0);
    chk("t3_pwm_q_dead", 32'(PWM_Q), 32'h3);
    repeat (3) nclk();
    chk("t3_pwm_q_last_dead", 32'(PWM_Q), 32'h3);
    nclk();
    chk("t3_pwm_q_off", 32'(PWM_Q), 32'h0);
    chk("t3_running", 32'(running), 32'h0);
    strobe(1'b1, 1'b1, 1'b0);
    repeat (10) nclk();
    chk("t3_startstop_running", 32'(running), 32'h0);
    chk("t3_startstop_pwm_q", 32'(PWM_Q), 32'h0);

    // 4: short during TON
    load(0, 16'd5);
    strobe(1'b1, 1'b0, 1'b0);
    wait_pwm_on("t4_wait_on");
    repeat (10) nclk();
    tgt = m_pulse + 1;
    strobe(1'b0, 1'b0, 1'b1);
    nclk();
`ifdef SHORT_PROTECT_EN
    chk("t4_abort_pwm", 32'(PWM), 32'h0);
    chk("t4_short_cnt", 32'(short_cnt), 32'd1);
    wait_pwm_on("t4_wait_next_on");
    chk("t4_double_toff", 32'(off_last), 32'd200);
`else
    chk("t4_pwm_held", 32'(PWM), 32'h07);
    wait_pulse("t4_wait_pulse", tgt);
    chk("t4_full_window", 32'(pwm_last), 32'd50);
    chk("t4_short_cnt", 32'(short_cnt), 32'd0);
    wait_pwm_on("t4_wait_next_on");
    chk("t4_normal_toff", 32'(off_last), 32'd100);
`endif
    // stop during TOFF
    tgt = m_pulse + 1;
    wait_pulse("t4_wait_toff", tgt);
    repeat (5) nclk();
    strobe(1'b0, 1'b1, 1'b0);
    nclk();
    chk("t4_toff_stop_running", 32'(running), 32'h0);
    chk("t4_toff_stop_pwm_q", 32'(PWM_Q), 32'h0);
    repeat (4) nclk();

    // 5: clamps Ton=0 Toff=0 Ip=12
    load(0, 16'd0); load(1, 16'd0); load(2, 16'd12);
    strobe(1'b1, 1'b0, 1'b0);
    tgt = m_pulse + 1;
    wait_pulse("t5_wait_pulse", tgt);
    chk("t5_pwm_window", 32'(pwm_last), 32'd10);
    chk("t5_pwm_value", 32'(pwm_peak), 32'hFF);
    wait_pwm_on("t5_wait_on");
    chk("t5_toff_window", 32'(off_last), 32'd20);
    strobe(1'b0, 1'b1, 1'b0);
    repeat (8) nclk();

    // 6: staircase, then asynchronous reset mid-TON
    load(3, 16'h0201); load(2, 16'd4); load(0, 16'd10);
    strobe(1'b1, 1'b0, 1'b0);
    wait_pwm_on("t6_wait_on");
    chk("t6_step0", 32'(PWM), 32'h01);
    repeat (20) nclk();
    chk("t6_step1", 32'(PWM), 32'h03);
    repeat (20) nclk();
    chk("t6_step2", 32'(PWM), 32'h07);
    repeat (20) nclk();
    chk("t6_step3", 32'(PWM), 32'h0F);
    repeat (30) nclk();
    chk("t6_hold", 32'(PWM), 32'h0F);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_async_pwm", 32'(PWM), 32'h0);
    chk("t6_async_pwm_q", 32'(PWM_Q), 32'h0);
    chk("t6_async_running", 32'(running), 32'h0);
    chk("t6_async_pulse_cnt", 32'(pulse_cnt), 32'h0);
    repeat (3) nclk();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) nclk();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
